// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared widths and state encodings for the UART program loader.
// UART_PARITY_EN adds the parity state to the rx encoding (8E1 frames).
package uart_loader_pkg;
  localparam int ISA_WIDTH = 32;
  localparam int ROM_DEPTH = 14;
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;
  typedef enum logic [1:0] {S_OFF, S_LOAD, S_DONE} sess_t;
endpackage

// File: rtl/uart_loader_rx.sv
// uart_rx_byte: synchronizes rx and deserializes one UART frame per byte.
// UART_PARITY_EN selects 8E1 framing; otherwise 8N1.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_byte_err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  logic            r_rx_m, r_rx_s, r_rx_prev;
  rx_state_t       r_state, w_state;
  logic [TW-1:0]   r_timer, w_timer;
  logic [2:0]      r_bit, w_bit;
  logic [7:0]      r_shift, w_shift;
  logic            w_mid, w_end, w_par_ok;
  assign w_mid = r_timer == TW'(CLKS_PER_BIT / 2 - 1);
  assign w_end = r_timer == TW'(CLKS_PER_BIT - 1);
  assign o_byte_data = r_shift;
`ifdef UART_PARITY_EN
  logic r_par_bad, w_par_bad;
  assign w_par_ok = !r_par_bad;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_par_bad <= 1'b0;
    else r_par_bad <= w_par_bad;
`else
  assign w_par_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_m    <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= RX_IDLE;
      r_timer   <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
    end else begin
      r_rx_m    <= i_rx;
      r_rx_s    <= r_rx_m;
      r_rx_prev <= r_rx_s;
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_bit     <= w_bit;
      r_shift   <= w_shift;
    end
  end
  always_comb begin
    w_state      = r_state;
    w_timer      = r_timer + TW'(1);
    w_bit        = r_bit;
    w_shift      = r_shift;
    o_byte_valid = 1'b0;
    o_byte_err   = 1'b0;
`ifdef UART_PARITY_EN
    w_par_bad    = r_par_bad;
`endif
    if (!i_en) begin
      w_state = RX_IDLE;
      w_timer = '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          w_timer = '0;
          if (r_rx_prev && !r_rx_s) w_state = RX_START;
        end
        RX_START:
          if (w_mid) begin
            w_timer = '0;
            w_bit   = '0;
            w_state = r_rx_s ? RX_IDLE : RX_DATA;
          end
        RX_DATA:
          if (w_end) begin
            w_timer = '0;
            w_shift = {r_rx_s, r_shift[7:1]};
            w_bit   = r_bit + 3'd1;
`ifdef UART_PARITY_EN
            if (r_bit == 3'd7) w_state = RX_PARITY;
`else
            if (r_bit == 3'd7) w_state = RX_STOP;
`endif
          end
`ifdef UART_PARITY_EN
        RX_PARITY:
          if (w_end) begin
            w_timer   = '0;
            w_par_bad = ^{r_shift, r_rx_s};
            w_state   = RX_STOP;
          end
`endif
        RX_STOP:
          if (w_end) begin
            w_timer      = '0;
            w_state      = RX_IDLE;
            o_byte_valid = r_rx_s && w_par_ok;
            o_byte_err   = !(r_rx_s && w_par_ok);
          end
        default: w_state = RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: assembles little-endian words from a UART byte stream and writes them
// to instruction/data memory during program download. UART_PARITY_EN selects 8E1 framing.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = ROM_DEPTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_uart_start,
  input  logic                  i_rx,
  output logic                  o_upg_wen,
  output logic [ADDR_WIDTH-1:0] o_upg_adr,
  output logic [ISA_WIDTH-1:0]  o_upg_dat,
  output logic                  o_upg_done,
  output logic                  o_busy,
  output logic                  o_frame_err
);
  sess_t                 r_sess, w_sess;
  logic [1:0]            r_byte_cnt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ISA_WIDTH-1:0]  r_dat;
  logic                  r_wen, r_done, r_err;
  logic                  w_en, w_valid, w_err, w_start, w_last;
  logic [7:0]            w_byte;
  assign w_en    = r_sess == S_LOAD;
  assign w_start = i_uart_start && !w_en;
  assign w_last  = r_wen && r_cnt == '1;
  assign o_upg_wen   = r_wen;
  assign o_upg_adr   = r_cnt;
  assign o_upg_dat   = r_dat;
  assign o_upg_done  = r_done;
  assign o_busy      = w_en;
  assign o_frame_err = r_err;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (w_en),
    .i_rx         (i_rx),
    .o_byte_valid (w_valid),
    .o_byte_data  (w_byte),
    .o_byte_err   (w_err)
  );
  always_comb begin
    w_sess = r_sess;
    if (w_start) w_sess = S_LOAD;
    else if (w_last) w_sess = S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sess     <= S_OFF;
      r_byte_cnt <= '0;
      r_cnt      <= '0;
      r_dat      <= '0;
      r_wen      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_sess <= w_sess;
      r_wen  <= 1'b0;
      if (w_start) begin
        r_cnt      <= '0;
        r_byte_cnt <= '0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end else begin
        if (w_err) r_err <= 1'b1;
        if (w_valid) begin
          r_dat[{r_byte_cnt, 3'b000} +: 8] <= w_byte;
          r_byte_cnt <= r_byte_cnt + 2'd1;
          r_wen      <= r_byte_cnt == 2'd3;
        end
        // the last address is held rather than wrapping into instruction memory
        if (w_last) r_done <= 1'b1;
        else if (r_wen) r_cnt <= r_cnt + ADDR_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized byte streams checked against a word-level download model.
module tb_uart_loader;
  localparam int CPB = 4;
  localparam int AW  = 3;
  logic          clk = 1'b0, rst_n = 1'b0, uart_start = 1'b0, rx = 1'b1;
  logic          upg_wen, upg_done, busy, frame_err;
  logic [AW-1:0] upg_adr;
  logic [31:0]   upg_dat;
  int            passed = 0, total = 0, cyc = 0, done_cyc = -1;
  logic [AW-1:0] s_adr[$];
  logic [31:0]   s_dat[$];
  int            s_cyc[$];
  logic [7:0]    model_bytes[$];

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_uart_start(uart_start), .i_rx(rx),
    .o_upg_wen(upg_wen), .o_upg_adr(upg_adr), .o_upg_dat(upg_dat),
    .o_upg_done(upg_done), .o_busy(busy), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (upg_wen === 1'b1) begin
      s_adr.push_back(upg_adr);
      s_dat.push_back(upg_dat);
      s_cyc.push_back(cyc);
    end
    if (upg_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  function automatic logic [31:0] exp_word(int i);
    return {model_bytes[4*i+3], model_bytes[4*i+2], model_bytes[4*i+1], model_bytes[4*i]};
  endfunction

  task automatic clear_obs();
    s_adr.delete(); s_dat.delete(); s_cyc.delete(); model_bytes.delete(); done_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_session();
    @(negedge clk) uart_start = 1'b1;
    @(negedge clk) uart_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB + $urandom_range(0, 3)) @(negedge clk);
    if (stop && !par_flip) model_bytes.push_back(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({upg_wen, upg_adr, upg_dat, upg_done, busy, frame_err} !== '0)
      $display("FAIL reset_outputs got wen=%b adr=%0d dat=%h done=%b busy=%b err=%b want all 0",
               upg_wen, upg_adr, upg_dat, upg_done, busy, frame_err);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_single_word();
    logic [7:0] bytes [4];
    bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    do_reset();
    start_session();
    clear_obs();
    total++;
    if (busy !== 1'b1) $display("FAIL single_busy_start got %b want 1", busy); else passed++;
    foreach (bytes[i]) send_byte(bytes[i], 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (s_adr.size() != 1) $display("FAIL single_strobes got %0d want 1", s_adr.size()); else passed++;
    if (s_adr.size() > 0) begin
      total++;
      if (s_adr[0] !== 3'd0) $display("FAIL single_adr got %0d want 0", s_adr[0]); else passed++;
      total++;
      if (s_dat[0] !== 32'h12345678) $display("FAIL single_dat got %h want 12345678", s_dat[0]); else passed++;
    end
    total++;
    if ({busy, upg_done, frame_err} !== 3'b100)
      $display("FAIL single_status got busy=%b done=%b err=%b want 1 0 0", busy, upg_done, frame_err);
    else passed++;
  endtask

  task automatic test_full_session();
    logic [31:0] w;
    do_reset();
    start_session();
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      w = 32'hA000_0000 + 32'(i);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    total++;
    if (s_adr.size() != 8) $display("FAIL full_strobes got %0d want 8", s_adr.size()); else passed++;
    for (int i = 0; i < 8 && i < s_adr.size(); i++) begin
      total++;
      if (s_adr[i] !== AW'(i) || s_dat[i] !== exp_word(i))
        $display("FAIL full_word%0d got adr=%0d dat=%h want adr=%0d dat=%h", i, s_adr[i], s_dat[i], i, exp_word(i));
      else passed++;
      total++;
      if (s_adr[i][AW-1] !== (i >= 4)) $display("FAIL full_msb%0d got %b want %b", i, s_adr[i][AW-1], i >= 4);
      else passed++;
    end
    total++;
    if ({upg_done, busy} !== 2'b10) $display("FAIL full_done got done=%b busy=%b want 1 0", upg_done, busy);
    else passed++;
    total++;
    if (s_cyc.size() != 8 || done_cyc != s_cyc[s_cyc.size()-1] + 1)
      $display("FAIL full_done_timing got done_cyc=%0d want one after last strobe", done_cyc);
    else passed++;
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (s_adr.size() != 8) $display("FAIL after_done_strobes got %0d want 8", s_adr.size()); else passed++;
  endtask

  task automatic test_random_words();
    int n;
    do_reset();
    start_session();
    clear_obs();
    for (int k = 0; k < 12 + 4 * $urandom_range(0, 1); k++) send_byte(8'($urandom), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    n = model_bytes.size() / 4;
    total++;
    if (s_adr.size() != n) $display("FAIL rand_strobes got %0d want %0d", s_adr.size(), n); else passed++;
    for (int i = 0; i < n && i < s_adr.size(); i++) begin
      total++;
      if (s_adr[i] !== AW'(i) || s_dat[i] !== exp_word(i))
        $display("FAIL rand_word%0d got adr=%0d dat=%h want adr=%0d dat=%h", i, s_adr[i], s_dat[i], i, exp_word(i));
      else passed++;
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    start_session();
    clear_obs();
    send_byte(8'($urandom), 1'b0, 1'b0);
    total++;
    if (frame_err !== 1'b1) $display("FAIL ferr_flag got %b want 1", frame_err); else passed++;
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (s_adr.size() != 1) $display("FAIL ferr_strobes got %0d want 1", s_adr.size()); else passed++;
    if (s_adr.size() > 0) begin
      total++;
      if (s_adr[0] !== 3'd0 || s_dat[0] !== 32'h04030201)
        $display("FAIL ferr_word got adr=%0d dat=%h want adr=0 dat=04030201", s_adr[0], s_dat[0]);
      else passed++;
    end
    total++;
    if (frame_err !== 1'b1) $display("FAIL ferr_sticky got %b want 1", frame_err); else passed++;
  endtask

  task automatic test_glitch();
    do_reset();
    start_session();
    clear_obs();
    rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (50) @(negedge clk);
    total++;
    if (s_adr.size() != 0 || frame_err !== 1'b0)
      $display("FAIL glitch_reject got strobes=%0d err=%b want 0 0", s_adr.size(), frame_err);
    else passed++;
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (s_adr.size() != 1 || s_dat[0] !== exp_word(0))
      $display("FAIL glitch_next_word got strobes=%0d dat=%h want 1 %h", s_adr.size(),
               s_dat.size() > 0 ? s_dat[0] : 32'h0, exp_word(0));
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_session();
    clear_obs();
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'($urandom_range(1, 255)), 1'b1, 1'b0);
    total++;
    if (busy !== 1'b1 || upg_dat === 32'h0)
      $display("FAIL mid_pre got busy=%b dat=%h want busy 1 and partial data", busy, upg_dat);
    else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({upg_wen, upg_adr, upg_dat, upg_done, busy, frame_err} !== '0)
      $display("FAIL mid_async_reset got wen=%b adr=%0d dat=%h done=%b busy=%b err=%b want all 0",
               upg_wen, upg_adr, upg_dat, upg_done, busy, frame_err);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_adr.size() != 0) $display("FAIL mid_no_strobe got %0d want 0", s_adr.size()); else passed++;
    start_session();
    clear_obs();
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (s_adr.size() != 1 || s_adr[0] !== 3'd0 || s_dat[0] !== exp_word(0))
      $display("FAIL mid_new_word got strobes=%0d dat=%h want 1 at adr 0 dat=%h", s_adr.size(),
               s_dat.size() > 0 ? s_dat[0] : 32'h0, exp_word(0));
    else passed++;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    do_reset();
    start_session();
    clear_obs();
    send_byte(8'h03, 1'b1, 1'b1);
    total++;
    if (frame_err !== 1'b1) $display("FAIL parity_err got %b want 1", frame_err); else passed++;
    send_byte(8'h03, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (s_adr.size() != 1 || s_dat[0] !== exp_word(0))
      $display("FAIL parity_word got strobes=%0d dat=%h want 1 %h", s_adr.size(),
               s_dat.size() > 0 ? s_dat[0] : 32'h0, exp_word(0));
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_full_session();
    test_random_words();
    test_frame_err();
    test_glitch();
    test_reset_mid();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
